wrap_tick_counter: RTL and testbench
====================================

# wrap_tick_counter

Downstream consumer of the modulo-6 counter stage. Samples the counter's `state[2:0]` and toggle output `out`, converts every `out` transition into a one-cycle `tick`, and accumulates ticks in a two-digit BCD count (00–59 by default) with a rollover pulse. It also checks that the upstream state sequence is legal and raises a sticky error flag otherwise.

## Interface
Parameters:
- `TENS_MAX`, default 5: highest tens digit; the count wraps after `TENS_MAX`9.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high; single clock domain
- `state`  in  3  upstream modulo counter value
- `out`  in  1  upstream toggle output; one transition per upstream wrap
- `enable`  in  1  high: ticks increment the BCD count; low: count holds
- `clear_err`  in  1  synchronous clear of `seq_err`
- `ones`  out  4  BCD ones digit, 0–9
- `tens`  out  4  BCD tens digit, 0–`TENS_MAX`
- `tick`  out  1  one-cycle pulse per detected `out` transition
- `rollover`  out  1  one-cycle pulse when the count wraps to 00
- `seq_err`  out  1  sticky illegal-sequence flag

## Operation
- Internal registers: `prev_out`, `prev_state[2:0]`, `hist_valid`.
- Reset values: `ones`=0, `tens`=0, `tick`=0, `rollover`=0, `seq_err`=0, `prev_out`=0, `prev_state`=0, `hist_valid`=0.
- Every cycle: `prev_out`<=`out`, `prev_state`<=`state`, `hist_valid`<=1.
- Edge detect: `edge` = `hist_valid` & (`out` != `prev_out`). Rising and falling transitions both count.
- `tick`<=`edge`, independent of `enable`.
- Increment when `edge` & `enable`:
  - `ones`<9: `ones`+1.
  - `ones`=9: `ones`<=0 and carry into tens.
  - On carry with `tens`=`TENS_MAX`: `tens`<=0 and `rollover`<=1. Otherwise `tens`+1.
- `rollover` is 0 in every other cycle.
- Sequence check runs only when `hist_valid`=1. Transition `prev_state`->`state` is legal when it is one of:
  - hold (s->s)
  - s->s+1 for s in 0..5 (5->6 is legal, the transient wrap value)
  - 6->0
  - any->0 (upstream reset)
- Any other transition, and any cycle with `state`=7, is illegal and sets `seq_err`<=1.
- `seq_err` clears only on `reset` or `clear_err`. If `clear_err` and a new violation occur in the same cycle, set wins.
- `enable` low: digits hold. Edge detection, `tick` and checking continue.

## Timing
- Latency is 1 clock. An `out` change sampled at edge k produces `tick`=1 and the updated digits in the cycle after edge k.
- Back-to-back `out` transitions on consecutive cycles produce consecutive `tick` pulses and increments; no edge is dropped.
- Reset mid-operation clears everything at that edge. The first sample after reset never produces `tick` or `seq_err`, because `hist_valid`=0 in that cycle.
- `reset` has priority over all other inputs.
- Nominal upstream input: `out` toggles every 6 cycles, giving one `tick` per 6 clocks. With default `TENS_MAX`, `rollover` fires every 360 clocks.

## Structure
- Shared package `counter_pkg` holds:
  - `BCD_W`=4
  - `ONES_MAX`=9
  - `STATE_W`=3
  - `STATE_WRAP`=6 (wrap value shared with the modulo counter stage)
  - `STATE_ILLEGAL`=7
- Sub-module `bcd_digit` implements one digit counter:
  - ports: `clk`, `reset`, `inc`, `max[3:0]`, `digit[3:0]`, `carry`
  - `carry` is combinational: `inc` & (`digit`==`max`)
  - instantiated twice: ones with `max`=9, tens with `max`=`TENS_MAX`
- Edge detector, sequence checker and output registers live in the top module.

## Test plan
- Reset, then drive `state` 0..5,6,0 repeatedly with `out` toggling every 6 cycles and `enable`=1 → `tick` every 6 clocks; `ones`=1 after the first tick; `seq_err` stays 0.
- 60 ticks with `enable`=1 from 00 → counts 59 then 00; `rollover`=1 for exactly the one cycle where digits read 00.
- `enable`=0 for 3 ticks at count 07 → `tick` pulses 3 times; digits stay 07.
- `state` jumps 2->4, then `clear_err` pulsed → `seq_err`=1 one cycle after the jump; 0 after the clear. Violation (`state`=7) in the same cycle as `clear_err` → `seq_err` stays 1.
- `out`=1 already at reset release, `state`=3 → no `tick` and no `seq_err` on the first sample; normal counting afterwards.
- `reset` asserted at count 42 mid-tick → all outputs 0 the next cycle; the pending edge is not counted.

Source files
------------

// File: rtl/counter_pkg.sv
// Constants shared between the modulo-6 counter stage and its downstream tick counter.
package counter_pkg;
  localparam int BCD_W = 4;
  localparam int STATE_W = 3;
  localparam logic [BCD_W-1:0] ONES_MAX = 4'd9;
  localparam logic [STATE_W-1:0] STATE_WRAP = 3'd6;
  localparam logic [STATE_W-1:0] STATE_ILLEGAL = 3'd7;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [STATE_W-1:0] state_t;
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit that counts 0..max and wraps; carry is combinational so digits chain in one cycle.
module bcd_digit
  import counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  bcd_t max,
  output bcd_t digit,
  output logic carry
);

  assign carry = inc & (digit == max);

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == max) ? '0 : bcd_t'(digit + 4'd1);
    end
  end

endmodule

// File: rtl/wrap_tick_counter.sv
// Turns each upstream toggle into a tick, counts ticks in two BCD digits and
// flags illegal upstream state sequences with a sticky error.
module wrap_tick_counter
  import counter_pkg::*;
#(
  parameter int TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  state_t     state,
  input  logic       out,
  input  logic       enable,
  input  logic       clear_err,
  output bcd_t       ones,
  output bcd_t       tens,
  output logic       tick,
  output logic       rollover,
  output logic       seq_err
);

  localparam bcd_t TENS_MAX_D = bcd_t'(TENS_MAX);

  logic   prev_out;
  state_t prev_state;
  logic   hist_valid;

  logic edge_det;
  logic inc_ones;
  logic ones_carry;
  logic tens_carry;
  logic seq_legal;
  logic seq_viol;

  // Input sample vs. history: edge detect and sequence legality
  always_comb begin
    edge_det  = hist_valid & (out != prev_out);
    inc_ones  = edge_det & enable;
    // 5->6 is the transient wrap value; any->0 covers an upstream reset
    seq_legal = (state == prev_state)
              | ((prev_state < STATE_WRAP) & (state == state_t'(prev_state + 3'd1)))
              | ((prev_state == STATE_WRAP) & (state == '0))
              | (state == '0);
    seq_viol  = hist_valid & ((state == STATE_ILLEGAL) | ~seq_legal);
  end

  bcd_digit u_ones (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_ones),
    .max   (ONES_MAX),
    .digit (ones),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .reset (reset),
    .inc   (ones_carry),
    .max   (TENS_MAX_D),
    .digit (tens),
    .carry (tens_carry)
  );

  // Registered history and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_out   <= 1'b0;
      prev_state <= '0;
      hist_valid <= 1'b0;
      tick       <= 1'b0;
      rollover   <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      prev_out   <= out;
      prev_state <= state;
      hist_valid <= 1'b1;
      tick       <= edge_det;
      rollover   <= tens_carry;
      // a new violation wins over a simultaneous clear
      if (seq_viol) begin
        seq_err <= 1'b1;
      end else if (clear_err) begin
        seq_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wrap_tick_counter.sv
// Scoreboard bench for wrap_tick_counter: the driver queues expected digits per toggle,
// a negedge monitor pops them whenever tick is high.
module tb_wrap_tick_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] state = 3'd0;
  logic       out = 1'b0;
  logic       enable = 1'b1;
  logic       clear_err = 1'b0;
  logic [3:0] ones, tens;
  logic       tick, rollover, seq_err;

  wrap_tick_counter #(.TENS_MAX(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .state     (state),
    .out       (out),
    .enable    (enable),
    .clear_err (clear_err),
    .ones      (ones),
    .tens      (tens),
    .tick      (tick),
    .rollover  (rollover),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ones;
    logic [3:0] tens;
    logic       roll;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cnt = 0;
  logic m_prev = 1'b0;
  bit   m_hv = 1'b0;
  logic ov = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Drive one cycle; a toggle seen with valid history queues the expected count.
  task automatic cyc(input logic [2:0] st, input logic o);
    exp_t e;
    state = st;
    out = o;
    if (reset) begin
      cnt = 0; m_hv = 0; m_prev = 1'b0;
    end else begin
      if (m_hv && (o != m_prev)) begin
        e.roll = 1'b0;
        if (enable) begin
          cnt = cnt + 1;
          if (cnt == 60) begin cnt = 0; e.roll = 1'b1; end
        end
        e.ones = 4'(cnt % 10);
        e.tens = 4'(cnt / 10);
        q.push_back(e);
      end
      m_prev = o; m_hv = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic toggle(input logic [2:0] st);
    ov = ~ov;
    cyc(st, ov);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (tick === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_tick", 1, 0);
      end else begin
        e = q.pop_front();
        check("sb_ones", ones, e.ones);
        check("sb_tens", tens, e.tens);
        check("sb_rollover", rollover, e.roll);
      end
    end else if (rollover === 1'b1) begin
      check("rollover_without_tick", 1, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // reset state
    cyc(3'd0, 1'b0);
    cyc(3'd0, 1'b0);
    check("rst_ones", ones, 0);
    check("rst_tens", tens, 0);
    check("rst_tick", tick, 0);
    check("rst_rollover", rollover, 0);
    check("rst_seq_err", seq_err, 0);
    reset = 1'b0;
    cyc(3'd0, 1'b0);

    // nominal upstream: toggle every 6 cycles, wrap via 6 on odd periods
    for (int per = 0; per < 10; per++) begin
      for (int k = 0; k < 6; k++) begin
        logic [2:0] st;
        st = (per % 2 == 0) ? 3'(k) : ((k == 0) ? 3'd6 : 3'(k - 1));
        if (k == 0) toggle(st);
        else cyc(st, ov);
        if (per == 0 && k == 0) begin
          check("first_tick", tick, 1);
          check("first_ones", ones, 1);
        end
        if (per == 0 && k == 1) check("no_tick_between", tick, 0);
      end
    end
    check("nominal_seq_err", seq_err, 0);
    check("nominal_ones", ones, 0);
    check("nominal_tens", tens, 1);

    // back-to-back toggles up to 59, then wrap
    cyc(3'd0, ov);
    for (int i = 0; i < 49; i++) toggle(3'd0);
    check("at59_ones", ones, 9);
    check("at59_tens", tens, 5);
    check("at59_rollover", rollover, 0);
    toggle(3'd0);
    check("wrap_ones", ones, 0);
    check("wrap_tens", tens, 0);
    check("wrap_rollover", rollover, 1);
    cyc(3'd0, ov);
    check("rollover_one_cycle", rollover, 0);

    // count to 07 then hold with enable low
    for (int i = 0; i < 7; i++) toggle(3'd0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      toggle(3'd0);
      check("disabled_tick", tick, 1);
    end
    check("hold_ones", ones, 7);
    check("hold_tens", tens, 0);
    enable = 1'b1;

    // sequence checker
    cyc(3'd1, ov);
    cyc(3'd2, ov);
    check("legal_seq", seq_err, 0);
    cyc(3'd4, ov);
    check("jump_2_4", seq_err, 1);
    clear_err = 1'b1;
    cyc(3'd4, ov);
    check("cleared", seq_err, 0);
    cyc(3'd7, ov);
    check("set_wins_over_clear", seq_err, 1);
    clear_err = 1'b0;
    cyc(3'd0, ov);
    check("sticky", seq_err, 1);
    clear_err = 1'b1;
    cyc(3'd0, ov);
    check("cleared_again", seq_err, 0);
    clear_err = 1'b0;

    // out already high at reset release, state 3
    reset = 1'b1;
    cyc(3'd0, ov);
    reset = 1'b0;
    ov = 1'b1;
    cyc(3'd3, ov);
    check("first_sample_tick", tick, 0);
    check("first_sample_seq_err", seq_err, 0);
    cyc(3'd4, ov);
    check("post_reset_seq_err", seq_err, 0);
    for (int i = 0; i < 42; i++) toggle(3'd4);
    check("at42_ones", ones, 2);
    check("at42_tens", tens, 4);

    // reset with a pending edge
    reset = 1'b1;
    toggle(3'd4);
    check("midrst_ones", ones, 0);
    check("midrst_tens", tens, 0);
    check("midrst_tick", tick, 0);
    check("midrst_rollover", rollover, 0);
    check("midrst_seq_err", seq_err, 0);
    reset = 1'b0;
    cyc(3'd4, ov);
    check("midrst_no_tick", tick, 0);
    toggle(3'd4);
    check("after_midrst_ones", ones, 1);
    cyc(3'd4, ov);

    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
